// File: rtl/mac_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_stream_unit
// Purpose  : Pipelined multiply-accumulate engine. It computes one dot product
//            per vector of streamed operand pairs. Operands are signed or
//            unsigned, chosen per vector. The accumulator can optionally
//            saturate, and a sticky overflow flag is kept for each vector.
//            Both the input and the result use valid/ready handshakes.
// Ports    : clk, rst        - clock (rising edge) and synchronous active-high
//                              reset
//            clear           - synchronous abort: flushes pipeline, accumulator
//            signed_mode     - operand signedness, sampled on a vector's first
//                              beat
//            in_valid/ready  - operand beat handshake (in_a, in_b, in_last)
//            out_valid/ready - result handshake (out_acc, out_count, out_ovf)
// Revision : 1.0 - initial release
// ============================================================================
module mac_stream_unit #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int COUNT_W  = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic               accept;

  logic               mode_q;
  logic               mode_eff;
  logic [PROD_W-1:0]  a_ext;
  logic [PROD_W-1:0]  b_ext;
  logic [PROD_W-1:0]  prod_d;
  logic [PROD_W-1:0]  prod_q;
  logic               prod_vld_q;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum_full;
  logic               add_ovf;
  logic [ACC_W-1:0]   sat_val;
  logic [ACC_W-1:0]   acc_add;

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic               ovf_q;
  logic               ovf_d;

  // --------------------------------------------------------------------------
  // Elaboration-time width check and widening of the product to ACC_W.
  // The product is extended only with the vector's latched mode.
  // --------------------------------------------------------------------------
  generate
    if (ACC_W < PROD_W) begin : g_bad_width
      $error("mac_stream_unit: ACC_W must be >= 2*DATA_W");
      assign prod_ext = prod_q[ACC_W-1:0];
    end else if (ACC_W == PROD_W) begin : g_ext_exact
      assign prod_ext = prod_q;
    end else begin : g_ext_wide
      assign prod_ext = {{(ACC_W-PROD_W){mode_q & prod_q[PROD_W-1]}}, prod_q};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          state_d = in_last ? S_DRAIN : S_ACCUM;
        end
      end
      S_DRAIN: begin
        // The final product is added during this one cycle.
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. in_ready also looks at rst/clear so that a beat offered
  // during an abort is never counted as accepted by the feeder.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM: in_ready  = !clear && !rst;
      S_HOLD:          out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Stage 1: multiply. On the first beat mode_q is not yet loaded, so the
  // live signed_mode pin is used. After that, the latched mode is used.
  // --------------------------------------------------------------------------
  assign mode_eff = (state_q == S_IDLE) ? signed_mode : mode_q;
  assign a_ext    = mode_eff ? {{DATA_W{in_a[DATA_W-1]}}, in_a} : {{DATA_W{1'b0}}, in_a};
  assign b_ext    = mode_eff ? {{DATA_W{in_b[DATA_W-1]}}, in_b} : {{DATA_W{1'b0}}, in_b};
  // The low PROD_W bits of the product of the extended operands are the
  // exact signed or unsigned product.
  assign prod_d   = a_ext * b_ext;

  // --------------------------------------------------------------------------
  // Stage 2: accumulate with overflow detection and optional clamping.
  // --------------------------------------------------------------------------
  assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};

  // Signed: both addends have the same sign, but the sum has the other sign.
  // Unsigned: carry out of the ACC_W-bit add.
  assign add_ovf = mode_q ?
                   ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum_full[ACC_W-1] != acc_q[ACC_W-1])) :
                   sum_full[ACC_W];

  // In signed mode, overflow can only occur toward the accumulator's own
  // sign. The accumulator sign therefore selects which limit to clamp to.
  assign sat_val = !mode_q         ? {ACC_W{1'b1}} :
                   acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};

  assign acc_add = (add_ovf && SATURATE) ? sat_val : sum_full[ACC_W-1:0];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_HOLD && out_ready) begin
      // Result consumed: return to the zeroed IDLE state.
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (prod_vld_q) begin
      acc_d = acc_add;
      cnt_d = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);
      ovf_d = ovf_q | add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mode_q     <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        prod_q <= prod_d;
      end
      if (accept && state_q == S_IDLE) begin
        mode_q <= signed_mode;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_stream_unit
// Purpose  : Self-checking bench for mac_stream_unit. Three instances share
//            the same stimulus:
//              A: ACC_W=32, COUNT_W=16, saturating
//              B: ACC_W=16, COUNT_W=4,  saturating
//              C: ACC_W=16, COUNT_W=16, wrapping
//            Each instance is compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_stream_unit;

  logic        clk = 1'b0;
  logic        rst, clear, signed_mode, in_valid, in_last, out_ready;
  logic [7:0]  in_a, in_b;

  logic        rdy_a, rdy_b, rdy_c;
  logic        ov_a, ov_b, ov_c;
  logic [31:0] acc_a;
  logic [15:0] acc_b, acc_c;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;
  logic        ovf_a, ovf_b, ovf_c;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] vec_a[$];
  logic [7:0] vec_b[$];
  bit         vec_m[$];

  longint e_a, e_b, e_c;
  bit     f_a, f_b, f_c;
  int     e_n;

  always #5 clk = ~clk;

  mac_stream_unit #(.DATA_W(8), .ACC_W(32), .COUNT_W(16), .SATURATE(1'b1)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(rdy_a), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a));

  mac_stream_unit #(.DATA_W(8), .ACC_W(16), .COUNT_W(4), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(rdy_b), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b));

  mac_stream_unit #(.DATA_W(8), .ACC_W(16), .COUNT_W(16), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(rdy_c), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_c), .out_ready(out_ready),
    .out_acc(acc_c), .out_count(cnt_c), .out_ovf(ovf_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the dot product computed as integers. The value is kept inside
  // the range representable at width aw. The signedness comes from the first
  // beat.
  function automatic void model(input int aw, input bit sat,
                                output longint acc_o, output bit ovf_o);
    longint acc, p, s, hi, lo, span;
    bit sm;
    sm    = vec_m[0];
    acc   = 0;
    ovf_o = 1'b0;
    span  = longint'(1) << aw;
    if (sm) begin hi = span / 2 - 1; lo = -(span / 2); end
    else    begin hi = span - 1;     lo = 0;           end
    foreach (vec_a[i]) begin
      if (sm) p = longint'($signed(vec_a[i])) * longint'($signed(vec_b[i]));
      else    p = longint'(vec_a[i]) * longint'(vec_b[i]);
      s = acc + p;
      if (s > hi || s < lo) begin
        ovf_o = 1'b1;
        if (sat) s = (s > hi) ? hi : lo;
        else begin
          s = ((s % span) + span) % span;
          if (sm && s > hi) s = s - span;
        end
      end
      acc = s;
    end
    acc_o = acc;
  endfunction

  task automatic new_vec();
    vec_a.delete(); vec_b.delete(); vec_m.delete();
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] b, input bit m);
    vec_a.push_back(a); vec_b.push_back(b); vec_m.push_back(m);
  endtask

  task automatic compute();
    model(32, 1'b1, e_a, f_a);
    model(16, 1'b1, e_b, f_b);
    model(16, 1'b0, e_c, f_c);
    e_n = vec_a.size();
  endtask

  task automatic check_fields(input string ph);
    chk({ph, " acc32_sat"}, acc_a, e_a[31:0]);
    chk({ph, " acc16_sat"}, acc_b, e_b[15:0]);
    chk({ph, " acc16_wrap"}, acc_c, e_c[15:0]);
    chk({ph, " count16"}, cnt_a, e_n);
    chk({ph, " count4"}, cnt_b, (e_n > 15) ? 15 : e_n);
    chk({ph, " count16_c"}, cnt_c, e_n);
    chk({ph, " ovf[a,b,c]"}, {ovf_a, ovf_b, ovf_c}, {f_a, f_b, f_c});
  endtask

  task automatic check_zero(input string ph);
    chk({ph, " out_valid"}, {ov_a, ov_b, ov_c}, 3'b000);
    chk({ph, " acc"}, {acc_a | acc_b | acc_c}, 32'h0);
    chk({ph, " count"}, {cnt_a | cnt_b | cnt_c}, 32'h0);
    chk({ph, " ovf"}, {ovf_a, ovf_b, ovf_c}, 3'b000);
  endtask

  // Starts just after a negedge with the DUTs able to accept. It ends at the
  // negedge that follows the last accepted beat.
  task automatic send_vec(input bit with_last);
    for (int i = 0; i < vec_a.size(); i++) begin
      in_valid    = 1'b1;
      in_a        = vec_a[i];
      in_b        = vec_b[i];
      signed_mode = vec_m[i];
      in_last     = with_last && (i == vec_a.size() - 1);
      #1;
      chk($sformatf("in_ready beat%0d", i), {rdy_a, rdy_b, rdy_c}, 3'b111);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Called at the DRAIN negedge. It checks latency, the result, stability
  // under backpressure and the release of the result.
  task automatic collect(input int hold);
    compute();
    chk("drain out_valid", {ov_a, ov_b, ov_c}, 3'b000);
    @(negedge clk);
    chk("hold out_valid", {ov_a, ov_b, ov_c}, 3'b111);
    check_fields("result");
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp out_valid", {ov_a, ov_b, ov_c}, 3'b111);
      chk("bp in_ready", {rdy_a, rdy_b, rdy_c}, 3'b000);
      check_fields("bp");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release in_ready", {rdy_a, rdy_b, rdy_c}, 3'b111);
    check_zero("release");
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b0; in_a = 8'h0; in_b = 8'h0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    chk("reset in_ready", {rdy_a, rdy_b, rdy_c}, 3'b000);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {rdy_a, rdy_b, rdy_c}, 3'b111);

    // Unsigned back-to-back beats: expected 65067 on the 32-bit instance.
    new_vec(); add(3, 4, 0); add(5, 6, 0); add(255, 255, 0);
    send_vec(1'b1);
    collect(0);
    chk("t1 literal", e_a[31:0], 32'd65067);

    // Signed. The mode toggle on beat 2 must be ignored: expected 16378.
    new_vec(); add(8'hFE, 8'h03, 1); add(8'h80, 8'h80, 0);
    send_vec(1'b1);
    collect(0);

    // Backpressure for 5 cycles, then a short vector.
    new_vec(); add(9, 11, 0); add(8'hF0, 8'h10, 0);
    send_vec(1'b1);
    collect(5);
    new_vec(); add(2, 2, 0);
    send_vec(1'b1);
    collect(0);

    // Overflow: unsigned saturate or wrap on 16 bits. Then a signed negative
    // clamp.
    new_vec(); add(255, 255, 0); add(255, 255, 0);
    send_vec(1'b1);
    collect(1);
    new_vec(); add(8'h80, 8'h7F, 1); add(8'h80, 8'h7F, 1); add(8'h80, 8'h7F, 1);
    send_vec(1'b1);
    collect(0);

    // Beat counter saturation on the 4-bit counter.
    new_vec();
    for (int i = 0; i < 20; i++) add(1, 1, 0);
    send_vec(1'b1);
    collect(0);

    // clear after two beats, with a beat offered during the clear.
    new_vec(); add(10, 10, 0); add(20, 20, 0);
    send_vec(1'b0);
    clear = 1'b1; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
    #1;
    chk("clear in_ready", {rdy_a, rdy_b, rdy_c}, 3'b000);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_zero("after clear");
      @(negedge clk);
    end
    new_vec(); add(7, 1, 0);
    send_vec(1'b1);
    collect(0);

    // rst while in DRAIN.
    new_vec(); add(100, 100, 0); add(50, 3, 0);
    send_vec(1'b1);
    rst = 1'b1;
    #1;
    chk("rst drain in_ready", {rdy_a, rdy_b, rdy_c}, 3'b000);
    @(negedge clk);
    check_zero("rst drain");
    rst = 1'b0;
    #1;
    chk("rst drain in_ready after", {rdy_a, rdy_b, rdy_c}, 3'b111);

    // rst while in HOLD.
    new_vec(); add(100, 100, 0);
    send_vec(1'b1);
    @(negedge clk);
    chk("pre-rst hold out_valid", {ov_a, ov_b, ov_c}, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst hold");
    rst = 1'b0;
    new_vec(); add(2, 3, 0);
    send_vec(1'b1);
    collect(0);

    // Randomized vectors: random length, data, signedness, gaps and backpressure.
    for (int v = 0; v < 30; v++) begin
      int len;
      bit m;
      len = $urandom_range(1, 6);
      m   = $urandom_range(0, 1);
      new_vec();
      for (int i = 0; i < len; i++) begin
        add($urandom, $urandom, (i == 0) ? m : bit'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_vec(1'b1);
      collect($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
